// File: rtl/tbird_lamp_controller.sv
// Thunderbird tail-light sequencer.
// Arbitrates left/right/hazard/brake requests, times each sequence step with an
// internal prescaler, and drives six registered lamp outputs from a Moore FSM.
// Lamp order, outer to outer: Lc Lb La | Ra Rb Rc.
module tbird_lamp_controller #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic hazard,
  input  logic brake,
  output logic Lc,
  output logic Lb,
  output logic La,
  output logic Ra,
  output logic Rb,
  output logic Rc,
  output logic busy,
  output logic tick
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] L1      = 4'd1;
  localparam logic [3:0] L2      = 4'd2;
  localparam logic [3:0] L3      = 4'd3;
  localparam logic [3:0] R1      = 4'd4;
  localparam logic [3:0] R2      = 4'd5;
  localparam logic [3:0] R3      = 4'd6;
  localparam logic [3:0] HAZ_ON  = 4'd7;
  localparam logic [3:0] HAZ_OFF = 4'd8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  // Lamp vector layout {Lc, Lb, La, Ra, Rb, Rc}.
  localparam logic [2:0] SIDE_OFF = 3'b000;
  localparam logic [2:0] SIDE_ALL = 3'b111;

  logic [3:0]       state;
  logic [3:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic             haz_req;
  logic             state_legal;
  logic [5:0]       lamps_q;
  logic [5:0]       lamps_next;
  logic             busy_next;

  // Both turn requests at once are treated exactly like a hazard request.
  assign haz_req     = hazard | (left & right);
  assign state_legal = (state <= HAZ_OFF);
  assign tick        = (state != IDLE) && (cnt == CNT_LAST);

  // Next-state logic: IDLE arbitrates every cycle, other states advance on tick.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      IDLE: begin
        if (haz_req)    next_state = HAZ_ON;
        else if (left)  next_state = L1;
        else if (right) next_state = R1;
        else            next_state = IDLE;
      end
      L1:      if (tick) next_state = haz_req ? HAZ_ON : L2;
      L2:      if (tick) next_state = haz_req ? HAZ_ON : L3;
      L3:      if (tick) next_state = haz_req ? HAZ_ON : IDLE;
      R1:      if (tick) next_state = haz_req ? HAZ_ON : R2;
      R2:      if (tick) next_state = haz_req ? HAZ_ON : R3;
      R3:      if (tick) next_state = haz_req ? HAZ_ON : IDLE;
      HAZ_ON:  if (tick) next_state = HAZ_OFF;
      HAZ_OFF: if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Lamp decode of the state being entered, with the brake overlay on the idle side.
  always_comb begin
    lamps_next = 6'b000000;
    busy_next  = (next_state != IDLE);
    case (next_state)
      IDLE:    lamps_next = brake ? {SIDE_ALL, SIDE_ALL} : 6'b000000;
      L1:      lamps_next = {3'b001, brake ? SIDE_ALL : SIDE_OFF};
      L2:      lamps_next = {3'b011, brake ? SIDE_ALL : SIDE_OFF};
      L3:      lamps_next = {3'b111, brake ? SIDE_ALL : SIDE_OFF};
      R1:      lamps_next = {brake ? SIDE_ALL : SIDE_OFF, 3'b100};
      R2:      lamps_next = {brake ? SIDE_ALL : SIDE_OFF, 3'b110};
      R3:      lamps_next = {brake ? SIDE_ALL : SIDE_OFF, 3'b111};
      HAZ_ON:  lamps_next = {SIDE_ALL, SIDE_ALL};
      HAZ_OFF: lamps_next = 6'b000000;
      default: lamps_next = 6'b000000;
    endcase
    // Recovery from a corrupted state register goes to IDLE with every lamp dark,
    // regardless of the brake pedal.
    if (!state_legal) begin
      lamps_next = 6'b000000;
      busy_next  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state so every flop
    // samples the pre-edge values and evaluation order does not matter.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Prescaler: held at 0 in IDLE, cleared on every state entry, wraps at TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (!reset)                                     cnt <= '0;
    else if ((next_state != state) || (state == IDLE)) cnt <= '0;
    else if (cnt == CNT_LAST)                       cnt <= '0;
    else                                            cnt <= cnt + 1'b1;
  end

  // Registered lamp and busy outputs reflect the state entered on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lamps_q <= 6'b000000;
      busy    <= 1'b0;
    end else begin
      lamps_q <= lamps_next;
      busy    <= busy_next;
    end
  end

  assign {Lc, Lb, La, Ra, Rb, Rc} = lamps_q;

endmodule

// File: tb/tb_tbird_lamp_controller.sv
// Scoreboard bench for tbird_lamp_controller (TICK_DIV=4).
// The stimulus process drives one cycle of inputs and pushes the hand-computed
// post-edge outputs into a queue; the monitor pops and compares on the falling edge.
module tb_tbird_lamp_controller;

  localparam logic [5:0] OFF  = 6'b000000;
  localparam logic [5:0] LA   = 6'b001000;
  localparam logic [5:0] LAB  = 6'b011000;
  localparam logic [5:0] LABC = 6'b111000;
  localparam logic [5:0] RA   = 6'b000100;
  localparam logic [5:0] RAB  = 6'b000110;
  localparam logic [5:0] ALL  = 6'b111111;

  logic clk;
  logic reset;
  logic left, right, hazard, brake;
  logic Lc, Lb, La, Ra, Rb, Rc;
  logic busy, tick;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  tbird_lamp_controller #(.TICK_DIV(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .left   (left),
    .right  (right),
    .hazard (hazard),
    .brake  (brake),
    .Lc     (Lc),
    .Lb     (Lb),
    .La     (La),
    .Ra     (Ra),
    .Rb     (Rb),
    .Rc     (Rc),
    .busy   (busy),
    .tick   (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lamps/busy/tick=%b expected %b", name, act, exp);
    end
  endtask

  // Monitor: one comparison per pushed expectation, away from the rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, {Lc, Lb, La, Ra, Rb, Rc, busy, tick}, e.exp);
    end
  end

  // One clock of stimulus; expectation is the output state after the edge.
  task automatic step(input logic rst_v, input logic l, input logic r, input logic h,
                      input logic b, input logic [5:0] lamps_e, input logic busy_e,
                      input logic tick_e, input string name);
    exp_t e;
    reset  = rst_v;
    left   = l;
    right  = r;
    hazard = h;
    brake  = b;
    @(posedge clk);
    e.exp  = {lamps_e, busy_e, tick_e};
    e.name = name;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;

    // 1: reset, then quiet idle with tick never asserting.
    for (int i = 0; i < 2; i++)  step(0, 0, 0, 0, 0, OFF, 0, 0, "t1_reset");
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, OFF, 0, 0, "t1_idle");

    // 2: left pulse; a stray right request mid-sequence is ignored.
    for (int i = 0; i < 4; i++) step(1, i == 0, 0, 0, 0, LA, 1, i == 3, "t2_L1");
    for (int i = 0; i < 4; i++) step(1, 0, i == 1, 0, 0, LAB, 1, i == 3, "t2_L2");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, LABC, 1, i == 3, "t2_L3");
    step(1, 0, 0, 0, 0, OFF, 0, 0, "t2_idle");
    step(1, 0, 0, 0, 0, OFF, 0, 0, "t2_idle2");

    // 3: right sequence preempted by hazard raised at e5.
    for (int i = 0; i < 4; i++) step(1, 0, i == 0, 0, 0, RA, 1, i == 3, "t3_R1");
    for (int i = 0; i < 4; i++) step(1, 0, 0, i >= 1, 0, RAB, 1, i == 3, "t3_R2");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, ALL, 1, i == 3, "t3_haz_on");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, OFF, 1, i == 3, "t3_haz_off");
    step(1, 0, 0, 0, 0, OFF, 0, 0, "t3_idle");
    step(1, 0, 0, 0, 0, OFF, 0, 0, "t3_idle2");

    // 4: left with brake held: right side forced on, then IDLE+brake, then release.
    for (int i = 0; i < 4; i++) step(1, i == 0, 0, 0, 1, 6'b001111, 1, i == 3, "t4_L1_brk");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 6'b011111, 1, i == 3, "t4_L2_brk");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, ALL, 1, i == 3, "t4_L3_brk");
    step(1, 0, 0, 0, 1, ALL, 0, 0, "t4_idle_brk");
    step(1, 0, 0, 0, 0, OFF, 0, 0, "t4_brk_release");

    // 5: left and right together act as hazard.
    for (int i = 0; i < 4; i++) step(1, i == 0, i == 0, 0, 0, ALL, 1, i == 3, "t5_haz_on");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, OFF, 1, i == 3, "t5_haz_off");
    step(1, 0, 0, 0, 0, OFF, 0, 0, "t5_idle");

    // 5b: held hazard passes through IDLE for one cycle and re-enters HAZ_ON;
    // brake is ignored during HAZ_OFF.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, ALL, 1, i == 3, "t5b_haz_on");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, OFF, 1, i == 3, "t5b_haz_off");
    step(1, 0, 0, 1, 0, OFF, 0, 0, "t5b_idle_gap");
    for (int i = 0; i < 4; i++) step(1, 0, 0, i == 0, 0, ALL, 1, i == 3, "t5b_haz_on2");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, OFF, 1, i == 3, "t5b_haz_off_brk");
    step(1, 0, 0, 0, 0, OFF, 0, 0, "t5b_idle");

    // 6: reset during L3, then a fresh left sequence.
    for (int i = 0; i < 4; i++) step(1, i == 0, 0, 0, 0, LA, 1, i == 3, "t6_L1");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, LAB, 1, i == 3, "t6_L2");
    step(1, 0, 0, 0, 0, LABC, 1, 0, "t6_L3");
    step(0, 0, 0, 0, 0, OFF, 0, 0, "t6_mid_reset");
    step(1, 0, 0, 0, 0, OFF, 0, 0, "t6_post_reset");
    for (int i = 0; i < 4; i++) step(1, i == 0, 0, 0, 0, LA, 1, i == 3, "t6_fresh_L1");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, LAB, 1, i == 3, "t6_fresh_L2");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, LABC, 1, i == 3, "t6_fresh_L3");
    step(1, 0, 0, 0, 0, OFF, 0, 0, "t6_idle");

    @(negedge clk);
    check("queue_drained", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
